video_overlay_mc: RTL and testbench

VIDEO_OVERLAY_MC -- requirements
Module: video_overlay_mc

---
 rtl/video_overlay_mc.sv | 154 +++++++++++++++
 tb/tb_video_overlay_mc.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_overlay_mc.sv
// Video overlay mixer: two-stage pixel pipeline choosing overlay, MOG-highlighted
// or camera video per pixel, with blinking overlays and per-frame overlay hit counting.
module video_overlay_mc #(
  parameter int unsigned PIX_W   = 16,
  parameter int unsigned N_OVL   = 4,
  parameter int unsigned BLINK_W = 4,
  parameter int unsigned CNT_W   = 22
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic                   in_sof,
  input  logic [3:0]             output_source,
  input  logic [N_OVL-1:0]       ovl_hit,
  input  logic [N_OVL-1:0]       ovl_blink_en,
  input  logic [N_OVL*PIX_W-1:0] ovl_color,
  input  logic                   mog_window_enable,
  input  logic                   mog_is_fg,
  input  logic [PIX_W/2-1:0]     video_grayscale_data,
  input  logic [PIX_W-1:0]       video_color_data,
  output logic                   out_valid,
  output logic                   out_sof,
  output logic [PIX_W-1:0]       video_data_out,
  output logic [CNT_W-1:0]       ovl_frame_pixels
);

  localparam int unsigned HALF_W = PIX_W / 2;
  localparam logic [HALF_W-1:0] MID   = {1'b1, {(HALF_W-1){1'b0}}};
  localparam logic [PIX_W-1:0]  WHITE = {{HALF_W{1'b1}}, MID};
  localparam logic [PIX_W-1:0]  BLACK = {{HALF_W{1'b0}}, MID};

  // frame-level state
  logic [3:0]         mode_q, mode_d;
  logic [BLINK_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               phase_q, phase_d;
  logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0]   frame_pix_q, frame_pix_d;

  // stage 1
  logic               s1_valid_q, s1_sof_q, s1_hit_q, s1_fg_q, s1_win_q;
  logic [3:0]         s1_mode_q;
  logic [PIX_W-1:0]   s1_ovl_q, s1_color_q;
  logic [HALF_W-1:0]  s1_gray_q;

  // stage 2
  logic               out_valid_q, out_sof_q;
  logic [PIX_W-1:0]   out_data_q;

  logic               acc_sof, phase_eff, hit_any, pix_inc;
  logic [3:0]         mode_eff;
  logic [PIX_W-1:0]   win_color, mix;

  // SOF pixel sees its own frame's mode and blink phase (bypass of the frame registers)
  always_comb begin
    acc_sof   = in_valid & in_sof;
    mode_eff  = acc_sof ? output_source : mode_q;
    phase_eff = acc_sof ? frame_cnt_q[BLINK_W-1] : phase_q;
    hit_any   = 1'b0;
    win_color = '0;
    for (int i = N_OVL - 1; i >= 0; i--) begin
      if (ovl_hit[i] && !(ovl_blink_en[i] && phase_eff)) begin
        hit_any   = 1'b1;
        win_color = ovl_color[i*PIX_W +: PIX_W];
      end
    end
  end

  // Frame counter, latched mode/phase and saturating overlay pixel counter
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    mode_d      = mode_q;
    pix_cnt_d   = pix_cnt_q;
    frame_pix_d = frame_pix_q;
    pix_inc     = in_valid & mode_eff[0] & hit_any;
    if (acc_sof) begin
      frame_cnt_d = frame_cnt_q + BLINK_W'(1);
      phase_d     = frame_cnt_q[BLINK_W-1];
      mode_d      = output_source;
      frame_pix_d = pix_cnt_q;
      pix_cnt_d   = {{(CNT_W-1){1'b0}}, pix_inc};
    end else if (pix_inc && (pix_cnt_q != {CNT_W{1'b1}})) begin
      pix_cnt_d = pix_cnt_q + CNT_W'(1);
    end
  end

  // Output selection; mode[3] overrides every non-overlay source with colour video
  always_comb begin
    mix = BLACK;
    if (s1_mode_q[0] && s1_hit_q) begin
      mix = s1_ovl_q;
    end else if (s1_mode_q[3]) begin
      mix = s1_color_q;
    end else if (!s1_mode_q[0]) begin
      mix = s1_mode_q[1] ? s1_color_q : {s1_gray_q, MID};
    end else if (s1_fg_q && s1_win_q) begin
      mix = s1_mode_q[1] ? s1_color_q : WHITE;
    end else if (s1_win_q || s1_mode_q[1]) begin
      mix = s1_color_q;
    end else if (s1_mode_q[2]) begin
      mix = {s1_gray_q, MID};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= '0;
      frame_cnt_q <= '0;
      phase_q     <= 1'b0;
      pix_cnt_q   <= '0;
      frame_pix_q <= '0;
      s1_valid_q  <= 1'b0;
      s1_sof_q    <= 1'b0;
      s1_hit_q    <= 1'b0;
      s1_fg_q     <= 1'b0;
      s1_win_q    <= 1'b0;
      s1_mode_q   <= '0;
      s1_ovl_q    <= '0;
      s1_color_q  <= '0;
      s1_gray_q   <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      mode_q      <= mode_d;
      frame_cnt_q <= frame_cnt_d;
      phase_q     <= phase_d;
      pix_cnt_q   <= pix_cnt_d;
      frame_pix_q <= frame_pix_d;
      s1_valid_q  <= in_valid;
      if (in_valid) begin
        s1_sof_q   <= in_sof;
        s1_hit_q   <= hit_any;
        s1_fg_q    <= mog_is_fg;
        s1_win_q   <= mog_window_enable;
        s1_mode_q  <= mode_eff;
        s1_ovl_q   <= win_color;
        s1_color_q <= video_color_data;
        s1_gray_q  <= video_grayscale_data;
      end
      out_valid_q <= s1_valid_q;
      out_sof_q   <= s1_valid_q & s1_sof_q;
      if (s1_valid_q) begin
        out_data_q <= mix;
      end
    end
  end

  assign out_valid        = out_valid_q;
  assign out_sof          = out_sof_q;
  assign video_data_out   = out_data_q;
  assign ovl_frame_pixels = frame_pix_q;

endmodule

// File: tb/tb_video_overlay_mc.sv
// Scoreboard bench for video_overlay_mc: a behavioural model pushes expected pixels
// when they are driven; each scenario task pops and compares as outputs appear.
module tb_video_overlay_mc;

  localparam int unsigned PIX_W   = 16;
  localparam int unsigned N_OVL   = 4;
  localparam int unsigned BLINK_W = 2;
  localparam int unsigned CNT_W   = 6;

  typedef struct {
    logic        sof;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_sof, mog_window_enable, mog_is_fg;
  logic [3:0]  output_source, ovl_hit, ovl_blink_en;
  logic [63:0] ovl_color;
  logic [7:0]  video_grayscale_data;
  logic [15:0] video_color_data;
  logic        out_valid, out_sof;
  logic [15:0] video_data_out;
  logic [5:0]  ovl_frame_pixels;

  // model state
  logic [3:0]  m_mode;
  int          m_fcnt;
  logic        m_phase;
  int          m_pcnt;
  exp_t        exp_q[$];
  int          cyc;
  int          errors;
  int          checks;

  video_overlay_mc #(.PIX_W(PIX_W), .N_OVL(N_OVL), .BLINK_W(BLINK_W), .CNT_W(CNT_W)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .in_valid             (in_valid),
    .in_sof               (in_sof),
    .output_source        (output_source),
    .ovl_hit              (ovl_hit),
    .ovl_blink_en         (ovl_blink_en),
    .ovl_color            (ovl_color),
    .mog_window_enable    (mog_window_enable),
    .mog_is_fg            (mog_is_fg),
    .video_grayscale_data (video_grayscale_data),
    .video_color_data     (video_color_data),
    .out_valid            (out_valid),
    .out_sof              (out_sof),
    .video_data_out       (video_data_out),
    .ovl_frame_pixels     (ovl_frame_pixels)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic model_reset;
    m_mode = 4'h0;
    m_fcnt = 0;
    m_phase = 1'b0;
    m_pcnt = 0;
    exp_q.delete();
  endtask

  // Expected result of the pixel currently on the inputs
  task automatic push_model;
    exp_t        e;
    int          win;
    logic [15:0] d;
    logic [15:0] gray_pix;
    if (!in_valid) return;
    if (in_sof) begin
      m_mode  = output_source;
      m_phase = (m_fcnt >= 2);
      m_fcnt  = (m_fcnt + 1) % 4;
      m_pcnt  = 0;
    end
    win = -1;
    for (int i = N_OVL - 1; i >= 0; i--)
      if (ovl_hit[i] && !(ovl_blink_en[i] && m_phase)) win = i;
    gray_pix = {video_grayscale_data, 8'h80};
    if (m_mode[0] && win >= 0) begin
      d = ovl_color[win*16 +: 16];
      if (m_pcnt < 63) m_pcnt++;
    end else if (m_mode[3]) d = video_color_data;
    else if (!m_mode[0]) d = m_mode[1] ? video_color_data : gray_pix;
    else if (mog_is_fg && mog_window_enable) d = m_mode[1] ? video_color_data : 16'hFF80;
    else if (mog_window_enable || m_mode[1]) d = video_color_data;
    else if (m_mode[2]) d = gray_pix;
    else d = 16'h0080;
    e.sof = in_sof;
    e.data = d;
    e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic set_in(input logic v, input logic sof, input logic [3:0] src,
                        input logic [3:0] hit, input logic [3:0] blink,
                        input logic fg, input logic win);
    in_valid = v;
    in_sof = sof;
    output_source = src;
    ovl_hit = hit;
    ovl_blink_en = blink;
    mog_is_fg = fg;
    mog_window_enable = win;
    video_grayscale_data = 8'($urandom);
    video_color_data = 16'($urandom);
  endtask

  task automatic tick;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic test_reset;
    set_in(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    ovl_color = '0;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    checks++; if (out_sof !== 1'b0) begin errors++; $display("FAIL reset_sof: got %0b want 0", out_sof); end
    checks++; if (video_data_out !== 16'h0) begin errors++; $display("FAIL reset_data: got %h want 0000", video_data_out); end
    checks++; if (ovl_frame_pixels !== 6'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", ovl_frame_pixels); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tick();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_release: out_valid=%0b want 0", out_valid); end
  endtask

  // Winner priority, blanking-free random mix, input gaps and output hold
  task automatic test_overlay;
    exp_t        e;
    logic [15:0] last;
    logic        seen = 1'b0;
    for (int i = 0; i < 43; i++) begin
      tick();
      if (i < 2) begin
        set_in(1'b1, i == 0, 4'h1, 4'b0110, 4'h0, 1'b1, 1'b1);
        ovl_color = {16'h5555, 16'h1234, 16'h8745, 16'hAAAA};
      end else if (i < 40) begin
        set_in($urandom_range(3) != 0, 1'b0, 4'($urandom), 4'($urandom), 4'($urandom),
               1'($urandom), 1'($urandom));
        ovl_color = {$urandom, $urandom};
      end else begin
        set_in(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
      end
      push_model();
      @(negedge clk);
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL overlay: unexpected out_valid data=%h", video_data_out);
        end else begin
          e = exp_q.pop_front();
          last = e.data;
          seen = 1'b1;
          if (out_sof !== e.sof || video_data_out !== e.data || cyc != e.cyc + 2) begin
            errors++;
            $display("FAIL overlay: got sof=%0b data=%h cyc=%0d want sof=%0b data=%h cyc=%0d",
                     out_sof, video_data_out, cyc, e.sof, e.data, e.cyc + 2);
          end
        end
      end else if (seen) begin
        checks++;
        if (video_data_out !== last) begin
          errors++; $display("FAIL overlay_hold: got %h want %h", video_data_out, last);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL overlay_drain: %0d outputs missing", exp_q.size()); end
  endtask

  // Back-to-back SOF pixels walking through the source-selection modes
  task automatic test_mog_modes;
    exp_t       e;
    logic [3:0] modes[10] = '{4'h1, 4'h5, 4'h1, 4'h1, 4'h3, 4'h0, 4'h2, 4'h9, 4'h9, 4'h4};
    logic [9:0] fg_v  = 10'b00_1011_0001;
    logic [9:0] win_v = 10'b00_1011_1001;
    logic [9:0] hit_v = 10'b01_0010_0000;
    for (int i = 0; i < 13; i++) begin
      tick();
      if (i < 10) begin
        set_in(1'b1, 1'b1, modes[i], {3'b000, hit_v[i]}, 4'h0, fg_v[i], win_v[i]);
        ovl_color = 64'h0_0000_0000_00BE;
        video_grayscale_data = 8'h5A;
        video_color_data = 16'hC3A5;
      end else begin
        set_in(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
      end
      push_model();
      @(negedge clk);
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL mog_modes: unexpected out_valid data=%h", video_data_out);
        end else begin
          e = exp_q.pop_front();
          if (out_sof !== e.sof || video_data_out !== e.data || cyc != e.cyc + 2) begin
            errors++;
            $display("FAIL mog_modes: got sof=%0b data=%h cyc=%0d want sof=%0b data=%h cyc=%0d",
                     out_sof, video_data_out, cyc, e.sof, e.data, e.cyc + 2);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL mog_drain: %0d outputs missing", exp_q.size()); end
  endtask

  // Mode changes mid-frame take effect only from the next SOF pixel
  task automatic test_mode_latch;
    exp_t e;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i < 6) set_in(1'b1, i == 0 || i == 4, (i == 0) ? 4'h1 : 4'h2, 4'h0, 4'h0, 1'b0, 1'b0);
      else set_in(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
      push_model();
      @(negedge clk);
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL mode_latch: unexpected out_valid data=%h", video_data_out);
        end else begin
          e = exp_q.pop_front();
          if (out_sof !== e.sof || video_data_out !== e.data || cyc != e.cyc + 2) begin
            errors++;
            $display("FAIL mode_latch: got sof=%0b data=%h cyc=%0d want sof=%0b data=%h cyc=%0d",
                     out_sof, video_data_out, cyc, e.sof, e.data, e.cyc + 2);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL latch_drain: %0d outputs missing", exp_q.size()); end
  endtask

  // 100-pixel frame with 37 hits, a saturating frame, then back-to-back SOFs
  task automatic test_frame_count;
    exp_t       e;
    logic       sof, hit;
    logic [5:0] want;
    for (int i = 0; i < 176; i++) begin
      tick();
      sof = (i == 0) || (i == 100) || (i == 170) || (i == 171) || (i == 172);
      hit = (i >= 1 && i <= 37) || (i >= 100 && i <= 169) || i == 171 || i == 172;
      if (i < 173) begin
        set_in(1'b1, sof, 4'h9, {1'b0, hit, 2'b00}, 4'h0, 1'($urandom), 1'($urandom));
        ovl_color = 64'h0000_7E57_0000_0000;
      end else begin
        set_in(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
      end
      push_model();
      @(negedge clk);
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL frame_count: unexpected out_valid data=%h", video_data_out);
        end else begin
          e = exp_q.pop_front();
          if (out_sof !== e.sof || video_data_out !== e.data || cyc != e.cyc + 2) begin
            errors++;
            $display("FAIL frame_count: got sof=%0b data=%h cyc=%0d want sof=%0b data=%h cyc=%0d",
                     out_sof, video_data_out, cyc, e.sof, e.data, e.cyc + 2);
          end
        end
      end
      if (i == 101 || i == 171 || i == 172 || i == 173) begin
        want = (i == 101) ? 6'd37 : (i == 171) ? 6'd63 : (i == 172) ? 6'd0 : 6'd1;
        checks++;
        if (ovl_frame_pixels !== want) begin
          errors++; $display("FAIL frame_pixels@%0d: got %0d want %0d", i, ovl_frame_pixels, want);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL count_drain: %0d outputs missing", exp_q.size()); end
  endtask

  // Short asynchronous reset pulse with pixels in flight
  task automatic test_reset_pulse;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      tick();
      set_in(1'b1, i == 0, 4'h3, 4'h0, 4'h0, 1'b0, 1'b0);
      push_model();
      @(negedge clk);
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL pulse_pre: unexpected out_valid data=%h", video_data_out);
        end else begin
          e = exp_q.pop_front();
          if (out_sof !== e.sof || video_data_out !== e.data || cyc != e.cyc + 2) begin
            errors++;
            $display("FAIL pulse_pre: got sof=%0b data=%h cyc=%0d want sof=%0b data=%h cyc=%0d",
                     out_sof, video_data_out, cyc, e.sof, e.data, e.cyc + 2);
          end
        end
      end
    end
    #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_sof, video_data_out, ovl_frame_pixels} !== 24'h0) begin
      errors++;
      $display("FAIL pulse_clear: valid=%0b sof=%0b data=%h cnt=%0d want all 0",
               out_valid, out_sof, video_data_out, ovl_frame_pixels);
    end
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL pulse_stale: out_valid=%0b want 0", out_valid); end
    end
  endtask

  // Frame n is the frame opened by the n-th SOF after reset (counting from 0);
  // ch0 blinks and falls through to ch1 while blanked
  task automatic test_blink;
    exp_t e;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 18; i++) begin
      tick();
      if (i < 15) begin
        set_in(1'b1, (i % 3) == 0, 4'h1, 4'b0011, 4'b0001, 1'b0, 1'b0);
        ovl_color = 64'h0000_0000_1111_ABCD;
      end else begin
        set_in(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
      end
      push_model();
      @(negedge clk);
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL blink: unexpected out_valid data=%h", video_data_out);
        end else begin
          e = exp_q.pop_front();
          if (out_sof !== e.sof || video_data_out !== e.data || cyc != e.cyc + 2) begin
            errors++;
            $display("FAIL blink: got sof=%0b data=%h cyc=%0d want sof=%0b data=%h cyc=%0d",
                     out_sof, video_data_out, cyc, e.sof, e.data, e.cyc + 2);
          end
        end
      end
      if (i == 1 || i == 4) begin
        checks++;
        if (ovl_frame_pixels !== ((i == 1) ? 6'd0 : 6'd3)) begin
          errors++; $display("FAIL blink_frame_pixels@%0d: got %0d want %0d", i, ovl_frame_pixels, (i == 1) ? 0 : 3);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL blink_drain: %0d outputs missing", exp_q.size()); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc = 0;
    model_reset();
    test_reset();
    test_overlay();
    test_mog_modes();
    test_mode_latch();
    test_frame_count();
    test_reset_pulse();
    test_blink();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
